// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the shared 8-bit memory port: registered owner FSM,
// round-robin tie-break, burst limit. Define MEM_PORT_ARBITER_STATS_EN for per-requester stall counters.
module mem_port_arbiter #(
    parameter int AW        = 8,
    parameter int DW        = 8,
    parameter int MAX_BURST = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          r0_req,
    input  logic [AW-1:0] r0_addr,
    input  logic          r0_we,
    input  logic [DW-1:0] r0_wdata,
    output logic          r0_gnt,
    output logic [DW-1:0] r0_rdata,
    output logic          r0_rvalid,
    input  logic          r1_req,
    input  logic [AW-1:0] r1_addr,
    input  logic          r1_we,
    input  logic [DW-1:0] r1_wdata,
    output logic          r1_gnt,
    output logic [DW-1:0] r1_rdata,
    output logic          r1_rvalid,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [15:0]   r0_wait_cnt,
    output logic [15:0]   r1_wait_cnt
);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);

    state_t     state;
    logic       rr_ptr;
    logic [3:0] burst_cnt;
    logic       own_req;
    logic       other_req;
    logic       keep_owner;

    assign r0_gnt = (state == OWN0);
    assign r1_gnt = (state == OWN1);

    // Current owner's view of the request lines; only meaningful in OWN0/OWN1.
    assign own_req    = r1_gnt ? r1_req : r0_req;
    assign other_req  = r1_gnt ? r0_req : r1_req;
    assign keep_owner = own_req && (!other_req || (burst_cnt != BURST_LAST));

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; the asynchronous reset puts them in a known state at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            rr_ptr    <= 1'b0;
            burst_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    burst_cnt <= '0;
                    if (r0_req && (!r1_req || !rr_ptr))
                        state <= OWN0;
                    else if (r1_req)
                        state <= OWN1;
                end
                OWN0, OWN1: begin
                    if (keep_owner) begin
                        if (burst_cnt != BURST_LAST)
                            burst_cnt <= burst_cnt + 4'd1;
                    end else begin
                        burst_cnt <= '0;
                        rr_ptr    <= (state == OWN0);
                        if (other_req)
                            state <= (state == OWN0) ? OWN1 : OWN0;
                        else
                            state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: every output of this block gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        if (r0_gnt) begin
            mem_addr  = r0_addr;
            mem_wdata = r0_wdata;
            mem_we    = r0_req & r0_we;
        end else if (r1_gnt) begin
            mem_addr  = r1_addr;
            mem_wdata = r1_wdata;
            mem_we    = r1_req & r1_we;
        end
    end

    // Read data is captured on the edge that ends a granted read cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r0_rdata  <= '0;
            r0_rvalid <= 1'b0;
            r1_rdata  <= '0;
            r1_rvalid <= 1'b0;
        end else begin
            r0_rvalid <= r0_gnt & r0_req & ~r0_we;
            r1_rvalid <= r1_gnt & r1_req & ~r1_we;
            if (r0_gnt && r0_req && !r0_we)
                r0_rdata <= mem_rdata;
            if (r1_gnt && r1_req && !r1_we)
                r1_rdata <= mem_rdata;
        end
    end

`ifdef MEM_PORT_ARBITER_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r0_wait_cnt <= '0;
            r1_wait_cnt <= '0;
        end else begin
            if (r0_req && !r0_gnt && (r0_wait_cnt != 16'hFFFF))
                r0_wait_cnt <= r0_wait_cnt + 16'd1;
            if (r1_req && !r1_gnt && (r1_wait_cnt != 16'hFFFF))
                r1_wait_cnt <= r1_wait_cnt + 16'd1;
        end
    end
`else
    assign r0_wait_cnt = '0;
    assign r1_wait_cnt = '0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a behavioural memory, a read-data queue
// per requester, and directed grant/latency/reset sequences.
module tb_mem_port_arbiter;

    logic        clk;
    logic        reset;
    logic        r0_req, r0_we, r0_gnt, r0_rvalid;
    logic [7:0]  r0_addr, r0_wdata, r0_rdata;
    logic        r1_req, r1_we, r1_gnt, r1_rvalid;
    logic [7:0]  r1_addr, r1_wdata, r1_rdata;
    logic [7:0]  mem_addr, mem_wdata, mem_rdata;
    logic        mem_we;
    logic [15:0] r0_wait_cnt, r1_wait_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] mem     [256];
    logic [7:0] ref_mem [256];
    logic [7:0] q0 [$];
    logic [7:0] q1 [$];

    mem_port_arbiter #(.AW(8), .DW(8), .MAX_BURST(4)) dut (
        .clk(clk), .reset(reset),
        .r0_req(r0_req), .r0_addr(r0_addr), .r0_we(r0_we), .r0_wdata(r0_wdata),
        .r0_gnt(r0_gnt), .r0_rdata(r0_rdata), .r0_rvalid(r0_rvalid),
        .r1_req(r1_req), .r1_addr(r1_addr), .r1_we(r1_we), .r1_wdata(r1_wdata),
        .r1_gnt(r1_gnt), .r1_rdata(r1_rdata), .r1_rvalid(r1_rvalid),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .r0_wait_cnt(r0_wait_cnt), .r1_wait_cnt(r1_wait_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Pop expected read data on each rvalid; push model data on each accepted read.
    always @(negedge clk) begin
        if (r0_rvalid) begin
            if (q0.size() == 0) check("r0_rvalid_unexpected", 1, 0);
            else check("r0_rdata_sb", {24'd0, r0_rdata}, {24'd0, q0.pop_front()});
        end
        if (r1_rvalid) begin
            if (q1.size() == 0) check("r1_rvalid_unexpected", 1, 0);
            else check("r1_rdata_sb", {24'd0, r1_rdata}, {24'd0, q1.pop_front()});
        end
        if (reset && r0_gnt && r0_req && !r0_we) q0.push_back(ref_mem[r0_addr]);
        if (reset && r1_gnt && r1_req && !r1_we) q1.push_back(ref_mem[r1_addr]);
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        r0_req = 0; r0_we = 0; r0_addr = 0; r0_wdata = 0;
        r1_req = 0; r1_we = 0; r1_addr = 0; r1_wdata = 0;
    endtask

    int exp_w0, exp_w1, own, pat;

    initial begin
        for (int i = 0; i < 256; i++) begin
            ref_mem[i] = 8'(i * 3 + 1);
            mem[i]    <= 8'(i * 3 + 1);
        end
        ref_mem[16] = 8'h2A;
        mem[16]    <= 8'h2A;
        reset = 0;
        clear_inputs();

        // Reset state
        #12;
        check("rst_r0_gnt", r0_gnt, 0);
        check("rst_r1_gnt", r1_gnt, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_rvalid", {r1_rvalid, r0_rvalid}, 0);
        check("rst_rdata", {r1_rdata, r0_rdata}, 0);
        check("rst_wait", {r1_wait_cnt, r0_wait_cnt}, 0);
        next_cycle();
        reset = 1;
        next_cycle();

        // r0 read from IDLE: gnt at +1, rvalid at +2
        r0_req = 1; r0_addr = 8'h10;
        @(negedge clk); check("t1_gnt_c0", r0_gnt, 0);
        next_cycle();
        @(negedge clk);
        check("t1_gnt_c1", r0_gnt, 1);
        check("t1_r1gnt_c1", r1_gnt, 0);
        check("t1_addr_c1", mem_addr, 8'h10);
        next_cycle();
        r0_req = 0;
        @(negedge clk);
        check("t1_rvalid_c2", r0_rvalid, 1);
        check("t1_rdata_c2", r0_rdata, 8'h2A);
        check("t1_r1gnt_c2", r1_gnt, 0);
        next_cycle();
        @(negedge clk); check("t1_rvalid_c3", r0_rvalid, 0);
        repeat (2) next_cycle();

        // r1 write F3 -> addr 5, then r0 reads it back
        r1_req = 1; r1_we = 1; r1_addr = 8'h05; r1_wdata = 8'hF3;
        @(negedge clk); check("t3_we_c0", mem_we, 0);
        next_cycle();
        @(negedge clk);
        check("t3_we_c1", mem_we, 1);
        check("t3_addr_c1", mem_addr, 8'h05);
        check("t3_wdata_c1", mem_wdata, 8'hF3);
        ref_mem[5] = 8'hF3;
        next_cycle();
        r1_req = 0;
        @(negedge clk);
        check("t3_we_c2", mem_we, 0);
        check("t3_no_rvalid", r1_rvalid, 0);
        next_cycle(); next_cycle();
        r1_we = 0;
        r0_req = 1; r0_addr = 8'h05;
        next_cycle();
        next_cycle();
        r0_req = 0;
        @(negedge clk);
        check("t3_rb_rvalid", r0_rvalid, 1);
        check("t3_rb_rdata", r0_rdata, 8'hF3);
        repeat (2) next_cycle();

        // r0 owner drops req while r1 requests
        r0_req = 1; r0_we = 1; r0_addr = 8'h40; r0_wdata = 8'h77;
        next_cycle();
        @(negedge clk);
        check("t4_gnt_c1", r0_gnt, 1);
        check("t4_we_c1", mem_we, 1);
        ref_mem[8'h40] = 8'h77;
        next_cycle();
        r0_req = 0; r1_req = 1; r1_we = 0; r1_addr = 8'h40;
        @(negedge clk);
        check("t4_gnt_drop", r0_gnt, 1);
        check("t4_we_drop", mem_we, 0);
        check("t4_r1gnt_drop", r1_gnt, 0);
        next_cycle();
        @(negedge clk);
        check("t4_own1_r1", r1_gnt, 1);
        check("t4_own1_r0", r0_gnt, 0);
        next_cycle();
        r1_req = 0; r0_we = 0;
        repeat (3) next_cycle();

        // Both requesting from reset: OWN0 x4, OWN1 x4, ...; wait counters over 20 cycles
        reset = 0;
        next_cycle();
        reset = 1;
        r0_req = 1; r0_addr = 8'h20;
        r1_req = 1; r1_addr = 8'h30;
        exp_w0 = 0; exp_w1 = 0;
        for (int k = 1; k <= 20; k++) begin
            own = (k == 1) ? 2 : (((k - 2) / 4) % 2);
            if (own != 0) exp_w0++;
            if (own != 1) exp_w1++;
            next_cycle();
            @(negedge clk);
            pat = ((k - 1) / 4) % 2;
            check($sformatf("t2_r0gnt_%0d", k), r0_gnt, (pat == 0));
            check($sformatf("t2_r1gnt_%0d", k), r1_gnt, (pat == 1));
        end
`ifdef MEM_PORT_ARBITER_STATS_EN
        check("t6_r0_wait", r0_wait_cnt, exp_w0);
        check("t6_r1_wait", r1_wait_cnt, exp_w1);
`else
        check("t6_r0_wait_off", r0_wait_cnt, 0);
        check("t6_r1_wait_off", r1_wait_cnt, 0);
`endif
        next_cycle();
        clear_inputs();
        repeat (3) next_cycle();

        // Reset mid-burst in OWN1 during a write
        r1_req = 1; r1_we = 1; r1_addr = 8'h50; r1_wdata = 8'h11;
        next_cycle();
        ref_mem[8'h50] = 8'h11;
        @(negedge clk); check("t5_own1", r1_gnt, 1);
        next_cycle();
        #1;
        check("t5_we_before", mem_we, 1);
        reset = 0;
        #1;
        check("t5_we_rst", mem_we, 0);
        check("t5_gnt_rst", r1_gnt, 0);
        next_cycle();
        reset = 1;
        r1_we = 0; r1_addr = 8'h60;
        r0_req = 1; r0_addr = 8'h61;
        next_cycle();
        @(negedge clk);
        check("t5_rr_r0", r0_gnt, 1);
        check("t5_rr_r1", r1_gnt, 0);
        next_cycle();
        clear_inputs();
        repeat (4) next_cycle();

        check("sb_q0_empty", q0.size(), 0);
        check("sb_q1_empty", q1.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
